// File: rtl/tpx3_rx_pkg.sv
// Shared definitions for the Timepix3 link receiver: sync FSM states, a
// constant-safe clog2 and the widths of the saturating statistics counters.
package tpx3_rx_pkg;

   typedef enum logic [2:0] {
      ST_WAIT   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SLIP   = 3'd2,
      ST_VERIFY = 3'd3,
      ST_LOCKED = 3'd4
   } sync_state_t;

   localparam int SLIP_CNT_W = 16;
   localparam int LOSS_CNT_W = 8;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/word_barrel_aligner.sv
// Word-clock barrel aligner: concatenates the previous valid word with the
// current one and picks a DSIZE window starting i_slip bits below the top.
module word_barrel_aligner
   import tpx3_rx_pkg::*;
#(
   parameter int DSIZE = 10,
   parameter int PW    = clog2(DSIZE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] i_word,
   input  logic             i_vld,
   input  logic [PW-1:0]    i_slip,
   output logic [DSIZE-1:0] o_word,
   output logic             o_vld
);

   logic [DSIZE-1:0]   r_prev_word;
   logic [2*DSIZE-1:0] w_cat;
   logic [2*DSIZE-1:0] w_shifted;
   logic [DSIZE-1:0]   w_aligned;

   // MSB is the earliest serial bit, so a larger slip moves the window later in time.
   assign w_cat     = {r_prev_word, i_word};
   assign w_shifted = w_cat << i_slip;
   assign w_aligned = w_shifted[2*DSIZE-1 -: DSIZE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_word <= '0;
         o_word      <= '0;
         o_vld       <= 1'b0;
      end else begin
         o_vld <= i_vld;
         if (i_vld) begin
            r_prev_word <= i_word;
            o_word      <= w_aligned;
         end
      end
   end

endmodule

// File: rtl/rec_sync_word_align.sv
// Word-level receiver sync: barrel alignment plus a hysteretic lock FSM driven
// by 8b10b decoder error feedback on the aligned output word.
module rec_sync_word_align
   import tpx3_rx_pkg::*;
#(
   parameter int DSIZE      = 10,
   parameter int WAIT_WORDS = 3,
   parameter int LOCK_GOOD  = 16,
   parameter int ERR_WINDOW = 64,
   parameter int ERR_MAX    = 4
) (
   input  logic                    WCLK,
   input  logic                    reset_n,
   // datain_vld qualifies datain for one cycle; there is no backpressure.
   input  logic [DSIZE-1:0]        datain,
   input  logic                    datain_vld,
   input  logic                    force_resync,
   input  logic                    decoder_err,
   output logic [DSIZE-1:0]        data,
   output logic                    data_vld,
   output logic                    rec_sync_ready,
   output logic [clog2(DSIZE)-1:0] slip_pos,
   output logic [SLIP_CNT_W-1:0]   slip_cnt,
   output logic [LOSS_CNT_W-1:0]   lock_loss_cnt,
   output sync_state_t             dbg_state
);

   localparam int PW     = clog2(DSIZE);
   localparam int WAIT_W = clog2(WAIT_WORDS + 1);
   localparam int GOOD_W = clog2(LOCK_GOOD + 1);
   localparam int WIN_W  = clog2(ERR_WINDOW + 1);
   localparam int ERR_W  = clog2(ERR_MAX + 1);

   sync_state_t           r_state;
   logic [WAIT_W-1:0]     r_wait_cnt;
   logic [GOOD_W-1:0]     r_good_cnt;
   logic [WIN_W-1:0]      r_win_cnt;
   logic [ERR_W-1:0]      r_err_cnt;
   logic [PW-1:0]         r_slip_pos;
   logic [SLIP_CNT_W-1:0] r_slip_cnt;
   logic [LOSS_CNT_W-1:0] r_loss_cnt;
   logic                  r_ready;
   logic [ERR_W-1:0]      w_err_sum;

   word_barrel_aligner #(
      .DSIZE (DSIZE),
      .PW    (PW)
   ) u_aligner (
      .clk    (WCLK),
      .rst_n  (reset_n),
      .i_word (datain),
      .i_vld  (datain_vld),
      .i_slip (r_slip_pos),
      .o_word (data),
      .o_vld  (data_vld)
   );

   assign w_err_sum = r_err_cnt + ERR_W'(decoder_err);

   always_ff @(posedge WCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_WAIT;
         r_wait_cnt <= '0;
         r_good_cnt <= '0;
         r_win_cnt  <= '0;
         r_err_cnt  <= '0;
         r_slip_pos <= '0;
         r_slip_cnt <= '0;
         r_loss_cnt <= '0;
         r_ready    <= 1'b0;
      end else if (force_resync) begin
         // Search restarts at the current offset; a coincident decoder error is irrelevant.
         if (r_state == ST_LOCKED && r_loss_cnt != '1)
            r_loss_cnt <= r_loss_cnt + 1'b1;
         r_state    <= ST_WAIT;
         r_wait_cnt <= '0;
         r_good_cnt <= '0;
         r_win_cnt  <= '0;
         r_err_cnt  <= '0;
         r_ready    <= 1'b0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (data_vld) begin
                  if (r_wait_cnt == WAIT_W'(WAIT_WORDS - 1)) begin
                     r_wait_cnt <= '0;
                     r_state    <= ST_CHECK;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               if (data_vld) begin
                  if (decoder_err) begin
                     r_state <= ST_SLIP;
                  end else begin
                     r_good_cnt <= GOOD_W'(1);
                     if (LOCK_GOOD == 1) begin
                        r_state <= ST_LOCKED;
                        r_ready <= 1'b1;
                     end else begin
                        r_state <= ST_VERIFY;
                     end
                  end
               end
            end
            ST_SLIP: begin
               r_slip_pos <= (r_slip_pos == PW'(DSIZE - 1)) ? '0 : r_slip_pos + 1'b1;
               if (r_slip_cnt != '1)
                  r_slip_cnt <= r_slip_cnt + 1'b1;
               r_state <= ST_WAIT;
            end
            ST_VERIFY: begin
               if (data_vld) begin
                  if (decoder_err) begin
                     r_good_cnt <= '0;
                     r_state    <= ST_SLIP;
                  end else begin
                     r_good_cnt <= r_good_cnt + 1'b1;
                     if (r_good_cnt == GOOD_W'(LOCK_GOOD - 1)) begin
                        r_state <= ST_LOCKED;
                        r_ready <= 1'b1;
                     end
                  end
               end
            end
            ST_LOCKED: begin
               if (data_vld) begin
                  if (w_err_sum == ERR_W'(ERR_MAX)) begin
                     // Keep slip_pos: a burst of errors usually does not mean the offset moved.
                     r_state    <= ST_WAIT;
                     r_ready    <= 1'b0;
                     r_win_cnt  <= '0;
                     r_err_cnt  <= '0;
                     r_good_cnt <= '0;
                     if (r_loss_cnt != '1)
                        r_loss_cnt <= r_loss_cnt + 1'b1;
                  end else if (r_win_cnt == WIN_W'(ERR_WINDOW - 1)) begin
                     r_win_cnt <= '0;
                     r_err_cnt <= '0;
                  end else begin
                     r_win_cnt <= r_win_cnt + 1'b1;
                     r_err_cnt <= w_err_sum;
                  end
               end
            end
            default: begin
               r_state <= ST_WAIT;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign rec_sync_ready = r_ready;
   assign slip_pos       = r_slip_pos;
   assign slip_cnt       = r_slip_cnt;
   assign lock_loss_cnt  = r_loss_cnt;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_rec_sync_word_align.sv
// Directed bench for rec_sync_word_align: comma stream alignment, lock hysteresis,
// window boundary, forced resync with gaps and asynchronous reset.
module tb_rec_sync_word_align;
   import tpx3_rx_pkg::*;

   localparam logic [9:0] K_WORD = 10'b0011111010;

   logic        WCLK = 1'b0;
   logic        reset_n;
   logic [9:0]  datain;
   logic        datain_vld;
   logic        force_resync;
   logic        inj_err;
   logic        decoder_err;
   logic [9:0]  data;
   logic        data_vld;
   logic        rec_sync_ready;
   logic [3:0]  slip_pos;
   logic [15:0] slip_cnt;
   logic [7:0]  lock_loss_cnt;
   sync_state_t dbg_state;

   int checks   = 0;
   int failures = 0;

   always #5 WCLK = ~WCLK;

   // Decoder model: any aligned word other than the comma is a code error.
   assign decoder_err = data_vld & (inj_err | (data != K_WORD));

   rec_sync_word_align dut (
      .WCLK           (WCLK),
      .reset_n        (reset_n),
      .datain         (datain),
      .datain_vld     (datain_vld),
      .force_resync   (force_resync),
      .decoder_err    (decoder_err),
      .data           (data),
      .data_vld       (data_vld),
      .rec_sync_ready (rec_sync_ready),
      .slip_pos       (slip_pos),
      .slip_cnt       (slip_cnt),
      .lock_loss_cnt  (lock_loss_cnt),
      .dbg_state      (dbg_state)
   );

   function automatic logic [9:0] rotl(input logic [9:0] v, input int s);
      logic [19:0] d;
      d = {v, v} << s;
      return d[19:10];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [9:0] w, input logic e, input logic fr);
      @(negedge WCLK);
      datain_vld   = v;
      datain       = w;
      inj_err      = e;
      force_resync = fr;
      @(posedge WCLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge WCLK);
      reset_n      = 1'b0;
      datain_vld   = 1'b0;
      inj_err      = 1'b0;
      force_resync = 1'b0;
      @(negedge WCLK);
      reset_n = 1'b1;
   endtask

   task automatic run_until_ready(input logic [9:0] w, input int max_steps, output int n);
      n = 0;
      while (rec_sync_ready !== 1'b1 && n < max_steps) begin
         step(1'b1, w, 1'b0, 1'b0);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [9:0]  r7;
      logic [9:0]  r9;
      logic        e;
      r7 = rotl(K_WORD, 3);
      r9 = rotl(K_WORD, 1);

      reset_n = 1'b0; datain = '0; datain_vld = 1'b0; force_resync = 1'b0; inj_err = 1'b0;
      repeat (2) @(posedge WCLK);
      #1;
      chk("rst_data", 32'(data), 32'h0);
      chk("rst_vld", 32'(data_vld), 32'h0);
      chk("rst_ready", 32'(rec_sync_ready), 32'h0);
      chk("rst_slip_pos", 32'(slip_pos), 32'h0);
      chk("rst_slip_cnt", 32'(slip_cnt), 32'h0);
      chk("rst_loss", 32'(lock_loss_cnt), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(ST_WAIT));
      @(negedge WCLK);
      reset_n = 1'b1;

      // 1: aligned comma stream, lock after 20 input words
      step(1'b1, K_WORD, 1'b0, 1'b0);
      chk("t1_first_vld", 32'(data_vld), 32'h1);
      chk("t1_first_data_prev0", 32'(data), 32'h0);
      step(1'b1, K_WORD, 1'b0, 1'b0);
      chk("t1_second_data", 32'(data), 32'(K_WORD));
      repeat (17) step(1'b1, K_WORD, 1'b0, 1'b0);
      chk("t1_not_ready_19", 32'(rec_sync_ready), 32'h0);
      step(1'b1, K_WORD, 1'b0, 1'b0);
      chk("t1_ready_20", 32'(rec_sync_ready), 32'h1);
      chk("t1_no_slips", 32'(slip_cnt), 32'h0);
      chk("t1_slip_pos", 32'(slip_pos), 32'h0);

      // 2: stream pre-rotated by 7 bits
      do_reset();
      run_until_ready(r7, 400, n);
      chk("t2_locked", 32'(rec_sync_ready), 32'h1);
      chk("t2_lock_steps", 32'(n), 32'd55);
      chk("t2_slip_cnt", 32'(slip_cnt), 32'd7);
      chk("t2_slip_pos", 32'(slip_pos), 32'd7);
      chk("t2_data", 32'(data), 32'(K_WORD));

      // 3: 3 errors in window keep lock, 4th drops it
      for (int i = 0; i <= 30; i++) begin
         e = (i == 2 || i == 10 || i == 20 || i == 30);
         step(1'b1, r7, e, 1'b0);
         if (i == 29) chk("t3_held_3err", 32'(rec_sync_ready), 32'h1);
      end
      chk("t3_dropped", 32'(rec_sync_ready), 32'h0);
      chk("t3_loss_cnt", 32'(lock_loss_cnt), 32'h1);
      chk("t3_slip_pos_kept", 32'(slip_pos), 32'd7);
      chk("t3_state_wait", 32'(dbg_state), 32'(ST_WAIT));
      run_until_ready(r7, 100, n);
      chk("t3_relock_steps", 32'(n), 32'd19);

      // 4: 3 errors ending on window word 63, 3 more from word 64
      for (int i = 0; i < 128; i++) begin
         e = (i == 10 || i == 20 || i == 63 || i == 64 || i == 70 || i == 80);
         step(1'b1, r7, e, 1'b0);
         if (i == 80) chk("t4_held_after_80", 32'(rec_sync_ready), 32'h1);
      end
      chk("t4_held_end", 32'(rec_sync_ready), 32'h1);
      chk("t4_loss_cnt", 32'(lock_loss_cnt), 32'h1);

      // 5: force_resync with coincident error, then gapped input
      step(1'b0, r7, 1'b1, 1'b1);
      chk("t5_ready_drop", 32'(rec_sync_ready), 32'h0);
      chk("t5_loss_cnt", 32'(lock_loss_cnt), 32'h2);
      chk("t5_no_extra_slip", 32'(slip_cnt), 32'd7);
      chk("t5_slip_pos", 32'(slip_pos), 32'd7);
      chk("t5_state_wait", 32'(dbg_state), 32'(ST_WAIT));
      for (int i = 1; i <= 19; i++) begin
         step(1'b1, r7, 1'b0, 1'b0);
         step(1'b0, r7, 1'b0, 1'b0);
         step(1'b0, r7, 1'b1, 1'b0);
         if (i == 1) begin
            chk("t5_gap_vld", 32'(data_vld), 32'h0);
            chk("t5_gap_hold", 32'(data), 32'(K_WORD));
         end
         if (i == 18) begin
            chk("t5_not_ready_18", 32'(rec_sync_ready), 32'h0);
            chk("t5_gap_slip_cnt", 32'(slip_cnt), 32'd7);
         end
      end
      chk("t5_relock_19", 32'(rec_sync_ready), 32'h1);

      // 6: async reset mid-VERIFY at slip_pos 9
      do_reset();
      n = 0;
      while (slip_pos !== 4'd9 && n < 200) begin
         step(1'b1, r9, 1'b0, 1'b0);
         n++;
      end
      chk("t6_reach_pos9_steps", 32'(n), 32'd46);
      chk("t6_slip_cnt", 32'(slip_cnt), 32'd9);
      repeat (6) step(1'b1, r9, 1'b0, 1'b0);
      chk("t6_state_verify", 32'(dbg_state), 32'(ST_VERIFY));
      @(negedge WCLK);
      #2;
      reset_n    = 1'b0;
      datain_vld = 1'b0;
      #1;
      chk("t6_async_data", 32'(data), 32'h0);
      chk("t6_async_vld", 32'(data_vld), 32'h0);
      chk("t6_async_ready", 32'(rec_sync_ready), 32'h0);
      chk("t6_async_slip_pos", 32'(slip_pos), 32'h0);
      chk("t6_async_slip_cnt", 32'(slip_cnt), 32'h0);
      chk("t6_async_loss", 32'(lock_loss_cnt), 32'h0);
      @(negedge WCLK);
      reset_n = 1'b1;
      repeat (19) step(1'b1, K_WORD, 1'b0, 1'b0);
      chk("t6_not_ready_19", 32'(rec_sync_ready), 32'h0);
      step(1'b1, K_WORD, 1'b0, 1'b0);
      chk("t6_ready_20", 32'(rec_sync_ready), 32'h1);
      chk("t6_slip_pos0", 32'(slip_pos), 32'h0);
      chk("t6_slip_cnt0", 32'(slip_cnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
